// File: rtl/serial_comp_ctrl_pkg.sv
// Shared definitions for the bit-serial comparator controllers:
// state encodings, result-flag bit positions and a flag packing helper.
package serial_comp_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int unsigned FLAG_GT = 0;
    localparam int unsigned FLAG_EQ = 1;
    localparam int unsigned FLAG_LT = 2;
    localparam int unsigned FLAG_W  = 3;

    // Pack the three compare outcomes into the result-flag vector.
    function automatic logic [FLAG_W-1:0] flag_vec(
        input logic gt,
        input logic eq,
        input logic lt
    );
        logic [FLAG_W-1:0] v;
        v          = '0;
        v[FLAG_GT] = gt;
        v[FLAG_EQ] = eq;
        v[FLAG_LT] = lt;
        return v;
    endfunction

endpackage

// File: rtl/serial_comp_ctrl_cmp_bit_cell.sv
// Combinational 1-bit magnitude compare cell: x versus y.
module cmp_bit_cell
    import serial_comp_ctrl_pkg::*;
(
    input  logic x,
    input  logic y,
    output logic gt,
    output logic eq,
    output logic lt
);

    assign gt = x & ~y;
    assign lt = ~x & y;
    assign eq = ~(x ^ y);

endmodule

// File: rtl/serial_comp_ctrl.sv
// Bit-serial unsigned magnitude comparator: walks latched operands MSB-first
// through one cmp_bit_cell and stops at the first differing bit.
module serial_comp_ctrl
    import serial_comp_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [WIDTH-1:0]         a,
    input  logic [WIDTH-1:0]         b,
    output logic                     busy,
    output logic                     done,
    output logic                     a_gt_b,
    output logic                     a_eq_b,
    output logic                     a_lt_b,
    output logic [$clog2(WIDTH):0]   bits_used
);

    localparam int unsigned IDX_W = $clog2(WIDTH);
    localparam int unsigned CNT_W = IDX_W + 1;

    state_e             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [IDX_W-1:0]   r_idx;
    logic [FLAG_W-1:0]  r_flags;
    logic [CNT_W-1:0]   r_bits_used;
    logic               r_busy;
    logic               r_done;

    state_e             w_state_nxt;
    logic [WIDTH-1:0]   w_a_nxt;
    logic [WIDTH-1:0]   w_b_nxt;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic [FLAG_W-1:0]  w_flags_nxt;
    logic [CNT_W-1:0]   w_bits_used_nxt;

    logic               w_bit_a;
    logic               w_bit_b;
    logic               w_gt;
    logic               w_eq;
    logic               w_lt;

    assign w_bit_a = r_a[r_idx];
    assign w_bit_b = r_b[r_idx];

    cmp_bit_cell u_cell (
        .x  (w_bit_a),
        .y  (w_bit_b),
        .gt (w_gt),
        .eq (w_eq),
        .lt (w_lt)
    );

    // State, operand, index and result registers; busy/done follow the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_idx       <= '0;
            r_flags     <= '0;
            r_bits_used <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_a         <= w_a_nxt;
            r_b         <= w_b_nxt;
            r_idx       <= w_idx_nxt;
            r_flags     <= w_flags_nxt;
            r_bits_used <= w_bits_used_nxt;
            r_busy      <= (w_state_nxt == ST_SCAN);
            r_done      <= (w_state_nxt == ST_DONE);
        end
    end

    // Next-state and datapath update.
    always_comb begin
        w_state_nxt     = r_state;
        w_a_nxt         = r_a;
        w_b_nxt         = r_b;
        w_idx_nxt       = r_idx;
        w_flags_nxt     = r_flags;
        w_bits_used_nxt = r_bits_used;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state_nxt     = ST_SCAN;
                    w_a_nxt         = a;
                    w_b_nxt         = b;
                    w_idx_nxt       = IDX_W'(WIDTH - 1);
                    w_flags_nxt     = '0;
                    w_bits_used_nxt = '0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (!w_eq) begin
                    w_state_nxt     = ST_DONE;
                    w_flags_nxt     = flag_vec(w_gt, 1'b0, w_lt);
                    w_bits_used_nxt = CNT_W'(WIDTH) - CNT_W'(r_idx);
                end else if (r_idx == '0) begin
                    // Last bit equal: leaving here is unconditional, idx never wraps.
                    w_state_nxt     = ST_DONE;
                    w_flags_nxt     = flag_vec(1'b0, 1'b1, 1'b0);
                    w_bits_used_nxt = CNT_W'(WIDTH);
                end else begin
                    w_idx_nxt = r_idx - IDX_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign a_gt_b    = r_flags[FLAG_GT];
    assign a_eq_b    = r_flags[FLAG_EQ];
    assign a_lt_b    = r_flags[FLAG_LT];
    assign bits_used = r_bits_used;

endmodule

// File: tb/tb_serial_comp_ctrl.sv
// Self-checking bench for serial_comp_ctrl (WIDTH=8 and WIDTH=2 instances)
// against a behavioural compare model.
module tb_serial_comp_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic       gt;
    logic       eq;
    logic       lt;
    logic [3:0] bits;

    logic       start2;
    logic [1:0] a2;
    logic [1:0] b2;
    logic       busy2;
    logic       done2;
    logic       gt2;
    logic       eq2;
    logic       lt2;
    logic [1:0] bits2;

    int vecs;
    int errs;

    serial_comp_ctrl #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .a_gt_b    (gt),
        .a_eq_b    (eq),
        .a_lt_b    (lt),
        .bits_used (bits)
    );

    serial_comp_ctrl #(.WIDTH(2)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .start     (start2),
        .a         (a2),
        .b         (b2),
        .busy      (busy2),
        .done      (done2),
        .a_gt_b    (gt2),
        .a_eq_b    (eq2),
        .a_lt_b    (lt2),
        .bits_used (bits2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: bits examined = position of first differing bit from the MSB, or w if equal.
    function automatic int model_bits(input logic [7:0] x, input logic [7:0] y, input int w);
        for (int i = w - 1; i >= 0; i--) begin
            if (x[i] != y[i]) return w - i;
        end
        return w;
    endfunction

    function automatic logic [2:0] model_flags(input logic [7:0] x, input logic [7:0] y);
        return {x < y, x == y, x > y};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One WIDTH=8 request from IDLE; checks latency, busy span, result and the done pulse width.
    task automatic run8(input logic [7:0] va, input logic [7:0] vb, input string tag);
        int         n;
        int         busy_cnt;
        int         eb;
        logic [2:0] ef;
        eb = model_bits(va, vb, 8);
        ef = model_flags(va, vb);
        a = va; b = vb; start = 1'b1;
        tick();
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom);
        n = 0;
        busy_cnt = 0;
        while (!done && n <= 12) begin
            vecs++;
            if (busy !== 1'b1 || {lt, eq, gt} !== 3'b000) begin
                errs++;
                $display("FAIL %s scan n=%0d: busy=%b flags=%b, want busy=1 flags=000", tag, n, busy, {lt, eq, gt});
            end
            busy_cnt++;
            tick();
            n++;
        end
        vecs++;
        if (done !== 1'b1 || n != eb || busy_cnt != eb || busy !== 1'b0) begin
            errs++;
            $display("FAIL %s latency: done=%b edges=%0d busy_cycles=%0d busy=%b, want done=1 edges=%0d busy_cycles=%0d busy=0",
                     tag, done, n, busy_cnt, busy, eb, eb);
        end
        vecs++;
        if ({lt, eq, gt} !== ef || bits !== 4'(eb)) begin
            errs++;
            $display("FAIL %s result a=%h b=%h: flags(lt,eq,gt)=%b bits=%0d, want %b bits=%0d",
                     tag, va, vb, {lt, eq, gt}, bits, ef, eb);
        end
        tick();
        vecs++;
        if (done !== 1'b0 || busy !== 1'b0 || {lt, eq, gt} !== ef || bits !== 4'(eb)) begin
            errs++;
            $display("FAIL %s after_done: done=%b busy=%b flags=%b bits=%0d, want done=0 busy=0 flags=%b bits=%0d",
                     tag, done, busy, {lt, eq, gt}, bits, ef, eb);
        end
    endtask

    task automatic test_reset();
        int seen_done;
        rst = 1'b1;
        tick();
        vecs++;
        if ({busy, done, gt, eq, lt} !== 5'b0 || bits !== 4'd0) begin
            errs++;
            $display("FAIL reset_por: busy,done,gt,eq,lt=%b bits=%0d, want 00000 bits=0", {busy, done, gt, eq, lt}, bits);
        end
        rst = 1'b0;
        a = 8'h80; b = 8'h80; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        vecs++;
        if (busy !== 1'b1) begin
            errs++;
            $display("FAIL reset_pre_abort: busy=%b, want 1", busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vecs++;
        if ({busy, done, gt, eq, lt} !== 5'b0 || bits !== 4'd0) begin
            errs++;
            $display("FAIL reset_mid_scan: busy,done,gt,eq,lt=%b bits=%0d, want 00000 bits=0", {busy, done, gt, eq, lt}, bits);
        end
        seen_done = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) seen_done++;
        end
        vecs++;
        if (seen_done != 0) begin
            errs++;
            $display("FAIL reset_no_done: active cycles after abort=%0d, want 0", seen_done);
        end
    endtask

    task automatic test_msb();
        run8(8'hA5, 8'h25, "msb_gt");
    endtask

    task automatic test_lsb();
        run8(8'h10, 8'h11, "lsb_lt");
    endtask

    task automatic test_equal();
        int bad;
        run8(8'h3C, 8'h3C, "equal");
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            a = 8'($urandom); b = 8'($urandom);
            tick();
            if ({lt, eq, gt} !== 3'b010 || bits !== 4'd8 || busy !== 1'b0 || done !== 1'b0) bad++;
        end
        vecs++;
        if (bad != 0) begin
            errs++;
            $display("FAIL equal_hold: bad idle cycles=%0d, want 0 (flags=%b bits=%0d)", bad, {lt, eq, gt}, bits);
        end
    endtask

    // start held high through SCAN, operands toggling; DONE with start high re-accepts immediately.
    task automatic test_back_to_back();
        int         n;
        logic [7:0] na;
        logic [7:0] nb;
        int         eb;
        a = 8'hF0; b = 8'hF8; start = 1'b1;
        tick();
        n = 0;
        while (!done && n <= 12) begin
            a = 8'($urandom); b = 8'($urandom);
            tick();
            n++;
        end
        vecs++;
        if (done !== 1'b1 || n != 5 || {lt, eq, gt} !== 3'b100 || bits !== 4'd5) begin
            errs++;
            $display("FAIL ignore_start: done=%b edges=%0d flags=%b bits=%0d, want done=1 edges=5 flags=100 bits=5",
                     done, n, {lt, eq, gt}, bits);
        end
        na = 8'($urandom);
        nb = (($urandom % 2) == 0) ? na ^ 8'(1 << ($urandom % 8)) : 8'($urandom);
        eb = model_bits(na, nb, 8);
        a = na; b = nb;
        tick();
        start = 1'b0;
        vecs++;
        if (busy !== 1'b1 || done !== 1'b0 || {lt, eq, gt} !== 3'b000 || bits !== 4'd0) begin
            errs++;
            $display("FAIL b2b_accept: busy=%b done=%b flags=%b bits=%0d, want busy=1 done=0 flags=000 bits=0",
                     busy, done, {lt, eq, gt}, bits);
        end
        n = 0;
        while (!done && n <= 12) begin
            a = 8'($urandom); b = 8'($urandom);
            tick();
            n++;
        end
        vecs++;
        if (done !== 1'b1 || n != eb || {lt, eq, gt} !== model_flags(na, nb) || bits !== 4'(eb)) begin
            errs++;
            $display("FAIL b2b_result a=%h b=%h: done=%b edges=%0d flags=%b bits=%0d, want done=1 edges=%0d flags=%b bits=%0d",
                     na, nb, done, n, {lt, eq, gt}, bits, eb, model_flags(na, nb), eb);
        end
        tick();
    endtask

    task automatic test_random();
        logic [7:0] ra;
        logic [7:0] rb;
        for (int k = 0; k < 40; k++) begin
            ra = 8'($urandom);
            case ($urandom % 3)
                0:       rb = ra;
                1:       rb = ra ^ 8'(1 << ($urandom % 8));
                default: rb = 8'($urandom);
            endcase
            run8(ra, rb, "random");
            repeat ($urandom % 3) tick();
        end
    endtask

    task automatic test_width2_sweep();
        int         pulses;
        int         n_at;
        logic [2:0] got;
        logic [1:0] got_bits;
        logic [7:0] xa;
        logic [7:0] xb;
        for (int i = 0; i < 16; i++) begin
            xa = 8'(i / 4);
            xb = 8'(i % 4);
            a2 = xa[1:0]; b2 = xb[1:0]; start2 = 1'b1;
            tick();
            start2 = 1'b0;
            pulses = 0; n_at = -1; got = '0; got_bits = '0;
            for (int c = 1; c <= 5; c++) begin
                tick();
                if (done2 === 1'b1) begin
                    pulses++;
                    if (n_at < 0) begin
                        n_at = c;
                        got = {lt2, eq2, gt2};
                        got_bits = bits2;
                    end
                end
            end
            vecs++;
            if (pulses != 1 || n_at != model_bits(xa, xb, 2) || got !== model_flags(xa, xb)
                || got_bits !== 2'(model_bits(xa, xb, 2)) || $countones(got) != 1) begin
                errs++;
                $display("FAIL w2_sweep a=%0d b=%0d: pulses=%0d edge=%0d flags=%b bits=%0d, want pulses=1 edge=%0d flags=%b bits=%0d",
                         xa, xb, pulses, n_at, got, got_bits, model_bits(xa, xb, 2), model_flags(xa, xb), model_bits(xa, xb, 2));
            end
        end
    endtask

    initial begin
        vecs   = 0;
        errs   = 0;
        rst    = 1'b1;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        start2 = 1'b0;
        a2     = '0;
        b2     = '0;
        @(negedge clk);
        test_reset();
        test_msb();
        test_lsb();
        test_equal();
        test_back_to_back();
        test_random();
        test_width2_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
